fp_accum_driver: RTL and testbench
==================================

// Module: fp_accum_driver
// PURPOSE
//   Sequences a running FP32 sum over groups of LEN operands for the matrix-multiply dot-product path.
//   Acts as the initiator of the stb/ack protocol toward a single-precision adder unit.
//   Accepts terms from an upstream producer and drives (acc, term) pairs into the adder.
//   Collects each adder result and presents the final group sum downstream.
// PARAMETERS
//   LEN    4    terms per group, >=1
//   CNT_W  $clog2(LEN)+1    term counter width (derived)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   reset; synchronous, active-low
//   in_data      in   32  FP32 term from producer
//   in_stb       in   1   in_data valid
//   in_ack       out  1   driver ready to take in_data
//   add_a        out  32  adder operand A (accumulator)
//   add_a_stb    out  1   add_a valid
//   add_a_ack    in   1   adder accepted A
//   add_b        out  32  adder operand B (term)
//   add_b_stb    out  1   add_b valid
//   add_b_ack    in   1   adder accepted B
//   add_z        in   32  adder result
//   add_z_stb    in   1   add_z valid
//   add_z_ack    out  1   driver ready for add_z
//   out_sum      out  32  FP32 group sum
//   out_sum_stb  out  1   out_sum valid
//   out_sum_ack  in   1   consumer accepted out_sum
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low.
// - Transfer rule: a transfer occurs on a rising edge where stb and ack are both 1.
//   - The stb side holds data stable until that edge.
//   - Both sides drop their signal the cycle after a transfer.
// - All outputs are registered.
// - Reset (rst==0 at an edge): state=GET_X, cnt=0, acc=0.
//   - All stb/ack outputs are 0.
//   - add_a, add_b and out_sum are 0.
//   - Any partial sum is discarded.
//   - The adder must be reset in the same cycle; the top level is responsible for this.
// - States:
//   - GET_X: in_ack=1 from the cycle after entry. On in transfer, term<=in_data.
//     - If cnt==0: acc<=in_data (bypass, no adder).
//       - Next state is PUT_SUM if LEN==1.
//       - Otherwise cnt<=1 and the state stays in GET_X.
//     - If cnt!=0: add_a<=acc, add_b<=in_data; next state SEND_A.
//   - SEND_A: add_a_stb=1 until an A transfer; then SEND_B.
//   - SEND_B: add_b_stb=1 until a B transfer; then GET_Z.
//     - B is never strobed before A has transferred.
//   - GET_Z: add_z_ack=1 until a Z transfer; on transfer acc<=add_z.
//     - If cnt==LEN-1: next state PUT_SUM, with out_sum<=add_z.
//     - Otherwise: cnt<=cnt+1, next state GET_X.
//   - PUT_SUM: out_sum_stb=1 with out_sum stable until an out transfer.
//     - Then acc<=0, cnt<=0, next state GET_X.
// - Backpressure: in_ack stays 0 outside GET_X, so the producer stalls while a term is in flight or the sum is pending.
// - Signals arriving outside their state are ignored:
//   - add_z_stb outside GET_Z (add_z_ack is 0 there).
//   - add_a_ack / add_b_ack while the matching stb is 0.
// - Arithmetic: no FP math in this block.
//   - The sum is exactly the adder chain ((t0+t1)+t2)+...
//   - NaN, Inf, zero and overflow handling are delegated to the adder.
// - Latency:
//   - Per term past the first: 1 cycle in GET_X plus the adder's handshake and compute time.
//   - After the final add_z transfer, out_sum_stb is asserted on the next cycle.
// - Throughput: one group in flight; there is no overlap between groups.
// TESTING
// Bench uses a behavioural stb/ack FP32 adder model with configurable random ack/stb delays.
// 1. LEN=4; terms 3F800000,40000000,40400000,40800000
//    -> a single out_sum=41200000 (10.0), and exactly 3 A and 3 B transfers.
// 2. LEN=1; term C0A00000
//    -> out_sum=C0A00000, with add_a_stb/add_b_stb never asserted.
// 3. Stalls:
//    - Hold add_a_ack=0 for 5 cycles -> add_a_stb and add_a held constant.
//    - Hold out_sum_ack=0 for 20 cycles -> out_sum_stb=1 and out_sum stable, with in_ack=0 throughout.
// 4. LEN=4; terms 3F800000,BF800000,40000000,C0000000
//    -> out_sum=00000000.
//    - Then a second group 1.0 x4 back-to-back -> out_sum=40800000.
// 5. Assert rst=0 for one cycle while in SEND_B
//    -> next cycle all stb/ack outputs are 0 and state is GET_X.
//    - A following 4-term group of 2.0 -> out_sum=41000000.
// 6. Spurious add_z_stb=1 pulsed during GET_X
//    -> no add_z_ack, acc unchanged, and the final sum is still correct.

Source files
------------

// File: rtl/fp_accum_driver.sv
// Running FP32 group sum sequencer. Takes LEN terms from a producer, chains them
// through an external stb/ack single-precision adder as ((t0+t1)+t2)+..., and
// presents the final group sum downstream. No floating-point math happens here.
module fp_accum_driver #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = $clog2(LEN) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_stb,
  output logic        in_ack,
  output logic [31:0] add_a,
  output logic        add_a_stb,
  input  logic        add_a_ack,
  output logic [31:0] add_b,
  output logic        add_b_stb,
  input  logic        add_b_ack,
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack,
  output logic [31:0] out_sum,
  output logic        out_sum_stb,
  input  logic        out_sum_ack
);

  typedef enum logic [2:0] {
    StGetX,
    StSendA,
    StSendB,
    StGetZ,
    StPutSum
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic [31:0]      out_sum_q, out_sum_d;
  logic             in_ack_q, in_ack_d;
  logic             add_a_stb_q, add_a_stb_d;
  logic             add_b_stb_q, add_b_stb_d;
  logic             add_z_ack_q, add_z_ack_d;
  logic             out_sum_stb_q, out_sum_stb_d;

  logic in_xfer, a_xfer, b_xfer, z_xfer, out_xfer;
  logic first_term, last_term;

  // Handshakes only complete against our own registered stb/ack, so strays are ignored.
  assign in_xfer  = in_stb & in_ack_q;
  assign a_xfer   = add_a_stb_q & add_a_ack;
  assign b_xfer   = add_b_stb_q & add_b_ack;
  assign z_xfer   = add_z_stb & add_z_ack_q;
  assign out_xfer = out_sum_stb_q & out_sum_ack;

  assign first_term = (cnt_q == '0);
  assign last_term  = (cnt_q == CNT_W'(LEN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StGetX;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StGetX: begin
        if (in_xfer) begin
          if (first_term) begin
            state_d = (LEN == 1) ? StPutSum : StGetX;
          end else begin
            state_d = StSendA;
          end
        end
      end
      StSendA:  if (a_xfer) state_d = StSendB;
      StSendB:  if (b_xfer) state_d = StGetZ;
      StGetZ:   if (z_xfer) state_d = last_term ? StPutSum : StGetX;
      StPutSum: if (out_xfer) state_d = StGetX;
      default:  state_d = StGetX;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    out_sum_d = out_sum_q;
    unique case (state_q)
      StGetX: begin
        if (in_xfer) begin
          if (first_term) begin
            // First term of a group bypasses the adder.
            acc_d = in_data;
            if (LEN == 1) begin
              out_sum_d = in_data;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end else begin
            add_a_d = acc_q;
            add_b_d = in_data;
          end
        end
      end
      StGetZ: begin
        if (z_xfer) begin
          acc_d = add_z;
          if (last_term) begin
            out_sum_d = add_z;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StPutSum: begin
        if (out_xfer) begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      default: ;
    endcase

    // in_ack rises the cycle after GET_X is entered and drops after each accepted term.
    in_ack_d      = (state_q == StGetX) && !in_xfer;
    // Strobes follow the next state, so they rise on entry and drop right after a transfer.
    add_a_stb_d   = (state_d == StSendA);
    add_b_stb_d   = (state_d == StSendB);
    add_z_ack_d   = (state_d == StGetZ);
    out_sum_stb_d = (state_d == StPutSum);
  end

  // Datapath and output registers; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      out_sum_q     <= '0;
      in_ack_q      <= 1'b0;
      add_a_stb_q   <= 1'b0;
      add_b_stb_q   <= 1'b0;
      add_z_ack_q   <= 1'b0;
      out_sum_stb_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      add_a_q       <= add_a_d;
      add_b_q       <= add_b_d;
      out_sum_q     <= out_sum_d;
      in_ack_q      <= in_ack_d;
      add_a_stb_q   <= add_a_stb_d;
      add_b_stb_q   <= add_b_stb_d;
      add_z_ack_q   <= add_z_ack_d;
      out_sum_stb_q <= out_sum_stb_d;
    end
  end

  assign in_ack      = in_ack_q;
  assign add_a       = add_a_q;
  assign add_a_stb   = add_a_stb_q;
  assign add_b       = add_b_q;
  assign add_b_stb   = add_b_stb_q;
  assign add_z_ack   = add_z_ack_q;
  assign out_sum     = out_sum_q;
  assign out_sum_stb = out_sum_stb_q;

endmodule

// File: tb/tb_fp_accum_driver.sv
// Bench for fp_accum_driver: stb/ack adder model with random delays, scoreboard
// queues filled by the stimulus and drained by output monitors.
module tb_fp_accum_driver;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_stb;
  logic        in_ack;
  logic [31:0] add_a;
  logic        add_a_stb;
  logic        add_a_ack;
  logic [31:0] add_b;
  logic        add_b_stb;
  logic        add_b_ack;
  logic [31:0] mz_data;
  logic        mz_stb;
  logic [31:0] spur_data;
  logic        spur_stb;
  logic        add_z_ack;
  logic [31:0] out_sum;
  logic        out_sum_stb;
  logic        out_sum_ack;

  // LEN=1 instance signals.
  logic [31:0] in1_data;
  logic        in1_stb;
  logic        in1_ack;
  logic [31:0] add1_a;
  logic        add1_a_stb;
  logic [31:0] add1_b;
  logic        add1_b_stb;
  logic        add1_z_ack;
  logic [31:0] out1_sum;
  logic        out1_stb;
  logic        out1_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];
  int n_out  = 0;
  int n_out1 = 0;
  int n_a    = 0;
  int n_b    = 0;
  int b_early = 0;
  int viol1  = 0;
  int rst_edges = 0;

  int cfg_a_dly = -1;
  int cfg_b_dly = -1;
  int cfg_z_dly = -1;
  int cfg_o_dly = -1;

  fp_accum_driver #(.LEN(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_stb      (in_stb),
    .in_ack      (in_ack),
    .add_a       (add_a),
    .add_a_stb   (add_a_stb),
    .add_a_ack   (add_a_ack),
    .add_b       (add_b),
    .add_b_stb   (add_b_stb),
    .add_b_ack   (add_b_ack),
    .add_z       (spur_stb ? spur_data : mz_data),
    .add_z_stb   (mz_stb | spur_stb),
    .add_z_ack   (add_z_ack),
    .out_sum     (out_sum),
    .out_sum_stb (out_sum_stb),
    .out_sum_ack (out_sum_ack)
  );

  fp_accum_driver #(.LEN(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in1_data),
    .in_stb      (in1_stb),
    .in_ack      (in1_ack),
    .add_a       (add1_a),
    .add_a_stb   (add1_a_stb),
    .add_a_ack   (1'b1),
    .add_b       (add1_b),
    .add_b_stb   (add1_b_stb),
    .add_b_ack   (1'b1),
    .add_z       (32'hDEADBEEF),
    .add_z_stb   (1'b1),
    .add_z_ack   (add1_z_ack),
    .out_sum     (out1_sum),
    .out_sum_stb (out1_stb),
    .out_sum_ack (out1_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!rst) rst_edges <= rst_edges + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    check(name, {31'd0, got}, {31'd0, exp});
  endtask

  // Exact FP32 encode/decode for small integers (|v| < 2^24).
  function automatic logic [31:0] i2f(input int v);
    int unsigned mag;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? int'(-v) : int'(v);
    p = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(mag << (23 - p));
    return r;
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int unsigned m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]} >> (23 - e);
    return f[31] ? -int'(m) : int'(m);
  endfunction

  function automatic int pick(input int c);
    return (c < 0) ? int'($urandom_range(0, 3)) : c;
  endfunction

  // Behavioural stb/ack adder; reset alongside the driver.
  initial begin
    int m_st, m_dly, seen_rst;
    logic a_seen, b_seen, z_pend;
    logic [31:0] a_val, b_val, a_cap, b_cap;
    add_a_ack = 1'b0; add_b_ack = 1'b0; mz_stb = 1'b0; mz_data = '0;
    m_st = 0; m_dly = 0; seen_rst = 0; a_seen = 0; b_seen = 0; z_pend = 0;
    a_val = '0; b_val = '0; a_cap = '0; b_cap = '0;
    forever begin
      @(negedge clk);
      if (rst_edges != seen_rst) begin
        seen_rst = rst_edges;
        m_st = 0; a_seen = 0; b_seen = 0; z_pend = 0;
        add_a_ack = 1'b0; add_b_ack = 1'b0; mz_stb = 1'b0;
      end else begin
        if (z_pend) begin
          mz_stb = 1'b0; z_pend = 0; m_st = 0;
        end
        add_a_ack = 1'b0;
        add_b_ack = 1'b0;
        case (m_st)
          0: begin
            if (add_b_stb) b_early++;
            if (a_seen) begin
              check1("add_a_stb_held", add_a_stb, 1'b1);
              check("add_a_held", add_a, a_cap);
            end
            if (add_a_stb) begin
              if (!a_seen) begin a_seen = 1; a_cap = add_a; m_dly = pick(cfg_a_dly); end
              if (m_dly == 0) begin
                add_a_ack = 1'b1; a_val = add_a; n_a++; a_seen = 0; m_st = 1;
              end else m_dly--;
            end
          end
          1: begin
            if (b_seen) begin
              check1("add_b_stb_held", add_b_stb, 1'b1);
              check("add_b_held", add_b, b_cap);
            end
            if (add_b_stb) begin
              if (!b_seen) begin b_seen = 1; b_cap = add_b; m_dly = pick(cfg_b_dly); end
              if (m_dly == 0) begin
                add_b_ack = 1'b1; b_val = add_b; n_b++; b_seen = 0; m_st = 2;
                m_dly = pick(cfg_z_dly);
              end else m_dly--;
            end
          end
          2: begin
            if (m_dly == 0) begin
              mz_data = i2f(f2i(a_val) + f2i(b_val)); mz_stb = 1'b1; m_st = 3;
            end else m_dly--;
          end
          default: ;
        endcase
        if (mz_stb && add_z_ack) z_pend = 1;
      end
    end
  end

  // Sum monitor for the LEN=4 instance.
  initial begin
    logic o_seen;
    logic [31:0] o_cap;
    int o_dly;
    out_sum_ack = 1'b0; o_seen = 0; o_cap = '0; o_dly = 0;
    forever begin
      @(negedge clk);
      out_sum_ack = 1'b0;
      if (o_seen) begin
        check1("out_sum_stb_held", out_sum_stb, 1'b1);
        check("out_sum_held", out_sum, o_cap);
      end
      if (out_sum_stb) begin
        check1("in_ack_low_while_sum", in_ack, 1'b0);
        if (!o_seen) begin o_seen = 1; o_cap = out_sum; o_dly = pick(cfg_o_dly); end
        if (o_dly == 0) begin
          out_sum_ack = 1'b1; o_seen = 0; n_out++;
          if (exp_q.size() == 0) check("out_sum_unexpected", out_sum, 32'hxxxxxxxx);
          else check("out_sum", out_sum, exp_q.pop_front());
        end else o_dly--;
      end
    end
  end

  // Sum monitor for the LEN=1 instance; its adder side must stay silent.
  initial begin
    out1_ack = 1'b0;
    forever begin
      @(negedge clk);
      out1_ack = 1'b0;
      if (add1_a_stb || add1_b_stb || add1_z_ack || add1_a != 32'h0 || add1_b != 32'h0) viol1++;
      if (out1_stb) begin
        out1_ack = 1'b1; n_out1++;
        if (exp1_q.size() == 0) check("out1_unexpected", out1_sum, 32'hxxxxxxxx);
        else check("out1_sum", out1_sum, exp1_q.pop_front());
      end
    end
  end

  task automatic send_term(input logic [31:0] d);
    int n;
    in_data = d; in_stb = 1'b1; n = 0;
    while (!in_ack && n < 500) begin @(negedge clk); n++; end
    check1("in_accept", in_ack, 1'b1);
    @(negedge clk);
    in_stb = 1'b0;
  endtask

  task automatic send1(input logic [31:0] d);
    int n;
    in1_data = d; in1_stb = 1'b1; n = 0;
    while (!in1_ack && n < 500) begin @(negedge clk); n++; end
    check1("in1_accept", in1_ack, 1'b1);
    @(negedge clk);
    in1_stb = 1'b0;
  endtask

  task automatic send_group(input logic [31:0] g [4]);
    for (int i = 0; i < 4; i++) send_term(g[i]);
  endtask

  task automatic wait_out(input int target);
    for (int i = 0; i < 3000 && n_out < target; i++) @(negedge clk);
    check("out_count", n_out, target);
  endtask

  task automatic rand_group();
    logic [31:0] g [4];
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      int v;
      v = int'($urandom_range(0, 2000)) - 1000;
      s += v;
      g[i] = i2f(v);
    end
    exp_q.push_back(i2f(s));
    send_group(g);
  endtask

  initial begin
    logic [31:0] grp [4];
    int na0, nb0, n;
    rst = 1'b0; in_stb = 1'b0; in_data = '0; in1_stb = 1'b0; in1_data = '0;
    spur_stb = 1'b0; spur_data = '0;
    repeat (3) @(negedge clk);
    check1("rst_in_ack", in_ack, 1'b0);
    check1("rst_add_a_stb", add_a_stb, 1'b0);
    check1("rst_add_b_stb", add_b_stb, 1'b0);
    check1("rst_add_z_ack", add_z_ack, 1'b0);
    check1("rst_out_sum_stb", out_sum_stb, 1'b0);
    check("rst_add_a", add_a, 32'h0);
    check("rst_add_b", add_b, 32'h0);
    check("rst_out_sum", out_sum, 32'h0);
    rst = 1'b1;

    // 1..4 -> 10.0 with exactly three adds.
    na0 = n_a; nb0 = n_b;
    grp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    exp_q.push_back(32'h41200000);
    send_group(grp);
    wait_out(1);
    check("a_transfers", n_a - na0, 3);
    check("b_transfers", n_b - nb0, 3);

    // Long A and output stalls.
    cfg_a_dly = 5; cfg_o_dly = 20;
    rand_group();
    wait_out(2);
    cfg_a_dly = -1; cfg_o_dly = -1;

    // Cancelling terms, then a back-to-back group of ones.
    grp = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000};
    exp_q.push_back(32'h00000000);
    send_group(grp);
    grp = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    exp_q.push_back(32'h40800000);
    send_group(grp);
    wait_out(4);

    // Reset while the driver waits in SEND_B.
    cfg_b_dly = 8;
    send_term(32'h40000000);
    send_term(32'h40000000);
    n = 0;
    while (!add_b_stb && n < 100) begin @(negedge clk); n++; end
    check1("reached_send_b", add_b_stb, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check1("mid_rst_add_a_stb", add_a_stb, 1'b0);
    check1("mid_rst_add_b_stb", add_b_stb, 1'b0);
    check1("mid_rst_add_z_ack", add_z_ack, 1'b0);
    check1("mid_rst_in_ack", in_ack, 1'b0);
    check1("mid_rst_out_sum_stb", out_sum_stb, 1'b0);
    @(negedge clk);
    check1("post_rst_in_ack", in_ack, 1'b1);
    cfg_b_dly = -1;
    grp = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    exp_q.push_back(32'h41000000);
    send_group(grp);
    wait_out(5);

    // Spurious add_z_stb while waiting for a term.
    exp_q.push_back(32'h41200000);
    send_term(32'h3F800000);
    n = 0;
    while (!in_ack && n < 100) begin @(negedge clk); n++; end
    spur_data = 32'h7F800001; spur_stb = 1'b1;
    check1("spur_z_ack0", add_z_ack, 1'b0);
    @(negedge clk);
    check1("spur_z_ack1", add_z_ack, 1'b0);
    spur_stb = 1'b0;
    send_term(32'h40000000);
    send_term(32'h40400000);
    send_term(32'h40800000);
    wait_out(6);

    // Random groups with random adder and consumer delays.
    for (int g = 0; g < 12; g++) rand_group();
    wait_out(18);

    // LEN=1 passes each term straight through.
    exp1_q.push_back(32'hC0A00000);
    send1(32'hC0A00000);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] v;
      v = $urandom;
      exp1_q.push_back(v);
      send1(v);
    end
    for (int i = 0; i < 100 && n_out1 < 6; i++) @(negedge clk);
    check("out1_count", n_out1, 6);
    check("len1_adder_silent", viol1, 0);
    check("b_before_a", b_early, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (checks %0d errors %0d)",
             n_checks, n_errors);
    $fatal(1);
  end

endmodule
